// File: rtl/dev_bus_arbiter.sv
// Two-master round-robin arbiter for the single bridge port; each transaction runs IDLE -> ACCESS -> DONE.
// Optional `DEV_ARB_ADDR_CHECK_EN` blocks accesses outside 0x7F00-0x7F1F (addr[15:4]) and flags them on err.
module dev_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          PrWE,
    output logic [AW-1:0] PrAddr,
    output logic [DW-1:0] Pr_WD,
    input  logic [DW-1:0] PrRD,
    output logic          err,
    output logic [1:0]    dbg_state
);

    // Handshake: a master holds reqN and its command stable until it samples ackN;
    // reqN still high in the cycle after ackN is a new request.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last_grant;
    logic          r_cmd_we;
    logic [AW-1:0] r_cmd_addr;
    logic [DW-1:0] r_cmd_wd;
    logic          r_cmd_id;
    logic          r_cmd_ok;
    logic [DW-1:0] r_rd;

    logic          w_grant;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wd;
    logic          w_addr_ok;
    logic          w_start;

    // On a tie the master that did not win last time takes the port.
    assign w_grant = (req0 && req1) ? ~r_last_grant : req1;
    assign w_we    = w_grant ? we1 : we0;
    assign w_addr  = w_grant ? addr1 : addr0;
    assign w_wd    = w_grant ? wdata1 : wdata0;
    assign w_start = (r_state == S_IDLE) && (req0 || req1);

`ifdef DEV_ARB_ADDR_CHECK_EN
    assign w_addr_ok = (w_addr[15:4] == 12'h7F0) || (w_addr[15:4] == 12'h7F1);
`else
    assign w_addr_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (req0 || req1) w_next = S_ACCESS;
            S_ACCESS: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_cmd_we     <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wd     <= '0;
            r_cmd_id     <= 1'b0;
            r_cmd_ok     <= 1'b0;
            r_rd         <= '0;
        end else begin
            if (w_start) begin
                r_last_grant <= w_grant;
                r_cmd_we     <= w_we;
                r_cmd_addr   <= w_addr;
                r_cmd_wd     <= w_wd;
                r_cmd_id     <= w_grant;
                r_cmd_ok     <= w_addr_ok;
            end
            // Blocked accesses return zero rather than whatever the bridge drives.
            if (r_state == S_ACCESS) begin
                r_rd <= r_cmd_ok ? PrRD : '0;
            end
        end
    end

    assign PrWE      = (r_state == S_ACCESS) && r_cmd_we && r_cmd_ok;
    assign PrAddr    = r_cmd_addr;
    assign Pr_WD     = r_cmd_wd;
    assign ack0      = (r_state == S_DONE) && !r_cmd_id;
    assign ack1      = (r_state == S_DONE) && r_cmd_id;
    assign rdata0    = r_rd;
    assign rdata1    = r_rd;
    assign dbg_state = r_state;

`ifdef DEV_ARB_ADDR_CHECK_EN
    assign err = (r_state == S_DONE) && !r_cmd_ok;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Bench for dev_bus_arbiter: scenario tasks with inline checks plus an ack scoreboard.
// The bridge is modelled as combinational read data derived from PrAddr unless a fixed value is forced.
module tb_dev_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int W  = 3 + DW;

`ifdef DEV_ARB_ADDR_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, PrWE, err;
    logic [DW-1:0] rdata0, rdata1, Pr_WD, PrRD;
    logic [AW-1:0] PrAddr;
    logic [1:0]    dbg_state;
    logic          prrd_fix_en = 1'b0;
    logic [DW-1:0] prrd_fix = '0;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  mon_e;
    logic [DW-1:0] mon_rd;
    int            n_vec = 0;
    int            n_err = 0;

    dev_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1),
        .PrWE(PrWE), .PrAddr(PrAddr), .Pr_WD(Pr_WD), .PrRD(PrRD),
        .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign PrRD = prrd_fix_en ? prrd_fix : (PrAddr ^ 32'hA5A5_0000);

    // ---------------- model helpers ----------------
    function automatic logic exp_err_of(input logic [AW-1:0] a);
        logic in_win;
        in_win = (a[15:4] == 12'h7F0) || (a[15:4] == 12'h7F1);
        return CHK_EN && !in_win;
    endfunction

    function automatic logic [DW-1:0] exp_rd_of(input logic [AW-1:0] a);
        return exp_err_of(a) ? '0 : (a ^ 32'hA5A5_0000);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic m, input logic r, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (m == 1'b0) begin
            req0 = r; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic push_exp(input logic m, input logic is_rd, input logic e, input logic [DW-1:0] rd);
        exp_q.push_back({m, is_rd, e, rd});
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && (ack0 || ack1)) begin
            n_vec++;
            if (ack0 && ack1) begin
                n_err++;
                $display("FAIL dual_ack: got ack0=1 ack1=1, want one ack at a time");
            end else if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b, want no ack", ack0, ack1);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_rd = ack1 ? rdata1 : rdata0;
                if ((ack1 !== mon_e[W-1]) || (err !== mon_e[W-3]) ||
                    (mon_e[W-2] && (mon_rd !== mon_e[DW-1:0]))) begin
                    n_err++;
                    $display("FAIL ack_scoreboard: got id=%0d err=%0b rdata=%h, want id=%0d err=%0b rdata=%h",
                             ack1, err, mon_rd, mon_e[W-1], mon_e[W-3], mon_e[DW-1:0]);
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_vec++;
        if ({ack0, ack1, err, PrWE} !== 4'b0 || PrAddr !== '0 || Pr_WD !== '0 ||
            rdata0 !== '0 || rdata1 !== '0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_values: got ack=%0b%0b err=%0b we=%0b addr=%h wd=%h rd=%h/%h st=%0d, want all 0",
                     ack0, ack1, err, PrWE, PrAddr, Pr_WD, rdata0, rdata1, dbg_state);
        end
        step();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            n_vec++;
            if ({ack0, ack1, err, PrWE} !== 4'b0 || PrAddr !== '0 || rdata0 !== '0) begin
                n_err++;
                $display("FAIL idle_quiet: cycle %0d got ack=%0b%0b err=%0b we=%0b addr=%h rd=%h, want 0",
                         c, ack0, ack1, err, PrWE, PrAddr, rdata0);
            end
        end
    endtask

    task automatic test_write0();
        set_req(1'b0, 1'b1, 1'b1, 32'h0000_7F04, 32'h1234_5678);
        push_exp(1'b0, 1'b0, exp_err_of(32'h0000_7F04), '0);
        for (int c = 1; c <= 3; c++) begin
            step();
            n_vec++;
            if (PrWE !== (c == 1) || ack0 !== (c == 2) || ack1 !== 1'b0) begin
                n_err++;
                $display("FAIL write0_timing: cycle %0d got we=%0b ack0=%0b ack1=%0b, want we=%0b ack0=%0b ack1=0",
                         c, PrWE, ack0, ack1, (c == 1), (c == 2));
            end
            if (c == 1) begin
                n_vec++;
                if (PrAddr !== 32'h0000_7F04 || Pr_WD !== 32'h1234_5678) begin
                    n_err++;
                    $display("FAIL write0_cmd: got addr=%h wd=%h, want 00007f04 12345678", PrAddr, Pr_WD);
                end
            end
            if (c == 2) req0 = 1'b0;
        end
    endtask

    task automatic test_read1();
        prrd_fix_en = 1'b1;
        prrd_fix    = 32'hCAFE_F00D;
        set_req(1'b1, 1'b1, 1'b0, 32'h0000_7F10, '0);
        push_exp(1'b1, 1'b1, exp_err_of(32'h0000_7F10), 32'hCAFE_F00D);
        for (int c = 1; c <= 3; c++) begin
            step();
            n_vec++;
            if (PrWE !== 1'b0 || ack1 !== (c == 2) || ack0 !== 1'b0) begin
                n_err++;
                $display("FAIL read1_timing: cycle %0d got we=%0b ack0=%0b ack1=%0b, want we=0 ack0=0 ack1=%0b",
                         c, PrWE, ack0, ack1, (c == 2));
            end
            if (c == 1) begin
                n_vec++;
                if (PrAddr !== 32'h0000_7F10) begin
                    n_err++;
                    $display("FAIL read1_addr: got %h, want 00007f10", PrAddr);
                end
            end
            if (c == 2) begin
                n_vec++;
                if (rdata0 !== 32'hCAFE_F00D) begin
                    n_err++;
                    $display("FAIL read1_rdata0_shared: got %h, want cafef00d", rdata0);
                end
                req1 = 1'b0;
            end
        end
        prrd_fix_en = 1'b0;
    endtask

    task automatic test_contention();
        logic [AW-1:0] a0, a1;
        a0 = 32'h0000_7F00;
        a1 = 32'h0000_7F14;
        reset = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, a0, '0);
        set_req(1'b1, 1'b1, 1'b0, a1, '0);
        for (int k = 0; k < 4; k++) begin
            push_exp(k[0], 1'b1, 1'b0, exp_rd_of(k[0] ? a1 : a0));
        end
        step();
        reset = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            step();
            n_vec++;
            if (ack0 !== (c == 2 || c == 8) || ack1 !== (c == 5 || c == 11)) begin
                n_err++;
                $display("FAIL contention_acks: cycle %0d got ack0=%0b ack1=%0b, want ack0=%0b ack1=%0b",
                         c, ack0, ack1, (c == 2 || c == 8), (c == 5 || c == 11));
            end
            if (c % 3 == 1 && c < 13) begin
                n_vec++;
                if (PrAddr !== (((c / 3) % 2 == 1) ? a1 : a0)) begin
                    n_err++;
                    $display("FAIL contention_grant: cycle %0d got addr=%h, want %h",
                             c, PrAddr, (((c / 3) % 2 == 1) ? a1 : a0));
                end
            end
            if (c == 11) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] wd;
        wd = 32'h1000_0000;
        set_req(1'b0, 1'b1, 1'b1, 32'h0000_7F08, wd);
        for (int k = 0; k < 3; k++) push_exp(1'b0, 1'b0, 1'b0, '0);
        for (int c = 1; c <= 9; c++) begin
            step();
            n_vec++;
            if (PrWE !== (c % 3 == 1) || ack0 !== (c % 3 == 2) || ack1 !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_timing: cycle %0d got we=%0b ack0=%0b ack1=%0b, want we=%0b ack0=%0b ack1=0",
                         c, PrWE, ack0, ack1, (c % 3 == 1), (c % 3 == 2));
            end
            if (c % 3 == 1) begin
                n_vec++;
                if (Pr_WD !== wd) begin
                    n_err++;
                    $display("FAIL b2b_wdata: cycle %0d got %h, want %h", c, Pr_WD, wd);
                end
            end
            if (c == 2 || c == 5) begin
                wd     = wd + 32'd1 + {16'd0, 16'($urandom_range(0, 255))};
                wdata0 = wd;
            end
            if (c == 8) req0 = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        set_req(1'b0, 1'b1, 1'b1, 32'h0000_7F0C, 32'h5555_AAAA);
        step();
        n_vec++;
        if (PrWE !== 1'b1) begin
            n_err++;
            $display("FAIL resetmid_access: got we=%0b, want 1", PrWE);
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (PrWE !== 1'b0 || ack0 !== 1'b0 || PrAddr !== '0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL resetmid_async: got we=%0b ack0=%0b addr=%h st=%0d, want 0 0 0 0",
                     PrWE, ack0, PrAddr, dbg_state);
        end
        req0 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            n_vec++;
            if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
                n_err++;
                $display("FAIL resetmid_noack: got ack0=%0b ack1=%0b, want 0 0", ack0, ack1);
            end
        end
        reset = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_7F18, '0);
        push_exp(1'b0, 1'b1, 1'b0, exp_rd_of(32'h0000_7F18));
        for (int c = 1; c <= 3; c++) begin
            step();
            n_vec++;
            if (ack0 !== (c == 2) || (c == 1 && PrAddr !== 32'h0000_7F18)) begin
                n_err++;
                $display("FAIL resetmid_recover: cycle %0d got ack0=%0b addr=%h, want ack0=%0b addr=00007f18",
                         c, ack0, PrAddr, (c == 2));
            end
            if (c == 2) req0 = 1'b0;
        end
    endtask

    task automatic test_addr_check();
        set_req(1'b0, 1'b1, 1'b1, 32'h0000_7F20, 32'hDEAD_BEEF);
        push_exp(1'b0, 1'b0, exp_err_of(32'h0000_7F20), '0);
        for (int c = 1; c <= 3; c++) begin
            step();
            n_vec++;
            if (PrWE !== (c == 1 && !CHK_EN) || ack0 !== (c == 2) || err !== (c == 2 && CHK_EN)) begin
                n_err++;
                $display("FAIL addrchk_write: cycle %0d got we=%0b ack0=%0b err=%0b, want we=%0b ack0=%0b err=%0b",
                         c, PrWE, ack0, err, (c == 1 && !CHK_EN), (c == 2), (c == 2 && CHK_EN));
            end
            if (c == 2) req0 = 1'b0;
        end
        set_req(1'b1, 1'b1, 1'b0, 32'h0000_8000, '0);
        push_exp(1'b1, 1'b1, exp_err_of(32'h0000_8000), exp_rd_of(32'h0000_8000));
        for (int c = 1; c <= 3; c++) begin
            step();
            n_vec++;
            if (PrWE !== 1'b0 || ack1 !== (c == 2) || err !== (c == 2 && CHK_EN)) begin
                n_err++;
                $display("FAIL addrchk_read: cycle %0d got we=%0b ack1=%0b err=%0b, want we=0 ack1=%0b err=%0b",
                         c, PrWE, ack1, err, (c == 2), (c == 2 && CHK_EN));
            end
            if (c == 2) req1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_write0();
        step();
        test_read1();
        step();
        test_contention();
        step();
        test_back_to_back();
        step();
        test_reset_mid();
        step();
        test_addr_check();
        step();
        step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_acks: got %0d outstanding, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
